// File: rtl/buffer_arbiter_pkg.sv
// Shared defaults and read-sequencer state encoding for the buffer arbiter.
package buffer_arbiter_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DWIDTH = 16;
  localparam int DEF_BURST  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// rotating pointer. The pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW:0]   w_idx_wide;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    gnt        = '0;
    w_found    = 1'b0;
    w_ptr_nxt  = r_ptr;
    w_idx_wide = '0;
    w_idx      = '0;
    for (int i = 0; i < N; i++) begin
      w_idx_wide = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_idx_wide >= (PW+1)'(N)) w_idx_wide = w_idx_wide - (PW+1)'(N);
      w_idx = w_idx_wide[PW-1:0];
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
        w_ptr_nxt  = (w_idx == PW'(N-1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_ptr <= '0;
    else if (|gnt) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/buffer_arbiter.sv
// Write arbiter and burst read sequencer for one shared show-ahead FIFO.
// Tracks occupancy itself; the buffer flags are only cross-checked.
module buffer_arbiter
  import buffer_arbiter_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int BURST  = DEF_BURST
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   buf_wr_en,
  output logic [DWIDTH-1:0]      buf_din,
  output logic                   buf_rd_en,
  input  logic [DWIDTH-1:0]      buf_dout,
  input  logic                   buf_full,
  input  logic                   buf_empty,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DWIDTH-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CAP       = CW'(DEPTH - 1);
  localparam logic [CW-1:0] BURST_LEN = CW'(BURST);

  arb_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_count, r_beat, r_len;
  logic          r_flush_pend;
  logic [NREQ-1:0] w_gnt;
  logic          w_load_burst, w_load_flush;

  // Reset gates the grant so producers holding valid see no ready while held.
  rr_arbiter #(.N(NREQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (rst_n && (r_count < CAP)),
    .gnt   (w_gnt)
  );

  assign req_ready = w_gnt;
  assign buf_wr_en = |w_gnt;

  always_comb begin
    buf_din = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) buf_din = req_data[i*DWIDTH +: DWIDTH];
  end

  always_comb begin
    w_state_nxt  = r_state;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    w_load_burst = 1'b0;
    w_load_flush = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count >= BURST_LEN) begin
          w_state_nxt  = ST_BURST;
          w_load_burst = 1'b1;
        end else if (r_flush_pend && (r_count != '0)) begin
          w_state_nxt  = ST_FLUSH;
          w_load_flush = 1'b1;
        end
      end
      ST_BURST, ST_FLUSH: begin
        out_valid = 1'b1;
        out_last  = (r_beat == r_len - 1'b1);
        if (out_ready && out_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign buf_rd_en = out_valid && out_ready;
  assign out_data  = buf_dout;
  assign busy      = (r_state != ST_IDLE);
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_beat       <= '0;
      r_len        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case ({buf_wr_en, buf_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load_burst) begin
        r_beat <= '0;
        r_len  <= BURST_LEN;
      end else if (w_load_flush) begin
        // Snapshot: words arriving during the flush wait for a later burst.
        r_beat <= '0;
        r_len  <= r_count;
      end else if (buf_rd_en) begin
        r_beat <= r_beat + 1'b1;
      end
      if (buf_rd_en && out_last && (r_state == ST_FLUSH)) r_flush_pend <= 1'b0;
      else if (flush)                                      r_flush_pend <= 1'b1;
    end
  end

  a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n) !(buf_rd_en && buf_empty));
  a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n) !(buf_wr_en && buf_full));
  a_count_bound:   assert property (@(posedge clk) disable iff (!rst_n) r_count <= CAP);

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter with a small show-ahead FIFO model
// standing in for the attached buffer.
module tb_buffer_arbiter;

  localparam int NREQ   = 4;
  localparam int DEPTH  = 8;
  localparam int DWIDTH = 16;
  localparam int BURST  = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   buf_wr_en, buf_rd_en, buf_full, buf_empty;
  logic [DWIDTH-1:0]      buf_din, buf_dout;
  logic                   flush;
  logic                   out_valid, out_last, out_ready, busy;
  logic [DWIDTH-1:0]      out_data;
  logic [3:0]             count;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [2:0]        wp, rp;
  logic [3:0]        occ;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  buffer_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .buf_wr_en (buf_wr_en),
    .buf_din   (buf_din),
    .buf_rd_en (buf_rd_en),
    .buf_dout  (buf_dout),
    .buf_full  (buf_full),
    .buf_empty (buf_empty),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .count     (count),
    .busy      (busy)
  );

  // Buffer model: capacity DEPTH-1, head word visible without a read.
  assign buf_dout  = mem[rp];
  assign buf_empty = (occ == 4'd0);
  assign buf_full  = (occ == 4'(DEPTH - 1));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (buf_wr_en) begin
        mem[wp] <= buf_din;
        wp      <= wp + 3'd1;
      end
      if (buf_rd_en) rp <= rp + 3'd1;
      occ <= occ + 4'(buf_wr_en) - 4'(buf_rd_en);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] dv(input int i);
    return 32'h1111 * (i + 1);
  endfunction

  initial begin
    int rr_cnt [14] = '{0, 1, 2, 3, 4, 5, 5, 5, 5, 5, 6, 6, 6, 6};
    int full_gnt [9] = '{1, 2, 4, 1, 2, 4, 1, 0, 0};
    logic ev;

    rst_n     = 1'b0;
    req_valid = 4'hF;
    flush     = 1'b0;
    out_ready = 1'b1;
    settle();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wr_en", 32'(buf_wr_en), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_count", 32'(count),     32'd0);
    do_reset();

    // Round-robin with all producers valid and a ready consumer.
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      settle();
      check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      check("rr_count", 32'(count), 32'(rr_cnt[c]));
      ev = ((c >= 5) && (c <= 8)) || (c >= 10);
      check("rr_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        check("rr_data", 32'(out_data), dv((c < 9) ? c - 5 : c - 10));
        check("rr_last", 32'(out_last), 32'((c == 8) || (c == 13)));
      end
      tick();
    end

    // Fill to capacity with the consumer stalled.
    do_reset();
    req_valid = 4'h7;
    out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      settle();
      check("full_grant", 32'(req_ready), 32'(full_gnt[c]));
      check("full_count", 32'(count), 32'((c < 7) ? c : 7));
      tick();
    end
    settle();
    check("full_held_valid", 32'(out_valid), 32'd1);
    check("full_held_data",  32'(out_data),  dv(0));
    out_ready = 1'b1;
    check("full_first_rd_ready", 32'(req_ready), 32'd0);
    check("full_first_rd_wr",    32'(buf_wr_en), 32'd0);
    tick();
    settle();
    check("full_resume_grant", 32'(req_ready), 32'd2);
    check("full_resume_count", 32'(count),     32'd6);
    check("full_resume_data",  32'(out_data),  dv(1));
    tick();
    // Simultaneous write and read around capacity.
    for (int k = 0; k < 14; k++) begin
      settle();
      check("full_onehot", 32'($onehot0(req_ready)), 32'd1);
      check("full_range",  32'((count >= 4'd6) && (count <= 4'd7)), 32'd1);
      if (k == 1) begin
        check("full_last",      32'(out_last), 32'd1);
        check("full_last_data", 32'(out_data), dv(0));
      end
      tick();
    end

    // Flush of a 3-word partial burst, with a 4th word arriving mid-flush.
    do_reset();
    req_valid = 4'h7;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("fl_grant", 32'(req_ready), 32'(1 << c));
      tick();
    end
    req_valid = 4'h0;
    flush     = 1'b1;
    settle();
    check("fl_count3", 32'(count),     32'd3);
    check("fl_idle0",  32'(out_valid), 32'd0);
    tick();
    flush = 1'b0;
    settle();
    check("fl_idle1", 32'(out_valid), 32'd0);
    tick();
    req_valid = 4'h8;
    settle();
    check("fl_busy",   32'(busy),      32'd1);
    check("fl_beat0",  32'(out_data),  dv(0));
    check("fl_nolast", 32'(out_last),  32'd0);
    check("fl_late_w", 32'(req_ready), 32'd8);
    tick();
    req_valid = 4'h0;
    settle();
    check("fl_beat1", 32'(out_data), dv(1));
    check("fl_cnt_b1", 32'(count),   32'd3);
    tick();
    settle();
    check("fl_beat2", 32'(out_data), dv(2));
    check("fl_last",  32'(out_last), 32'd1);
    tick();
    settle();
    check("fl_done_valid", 32'(out_valid), 32'd0);
    check("fl_left_count", 32'(count),     32'd1);
    tick();
    settle();
    check("fl_pend_clear", 32'(busy), 32'd0);
    tick();

    // Flush requested while empty; one word arrives five cycles later.
    do_reset();
    out_ready = 1'b1;
    flush     = 1'b1;
    settle();
    check("fe_idle", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0;
    for (int c = 1; c < 5; c++) begin
      settle();
      check("fe_wait", 32'(out_valid), 32'd0);
      tick();
    end
    req_valid = 4'h1;
    settle();
    check("fe_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 4'h0;
    settle();
    check("fe_count1", 32'(count),     32'd1);
    check("fe_notyet", 32'(out_valid), 32'd0);
    tick();
    settle();
    check("fe_valid", 32'(out_valid), 32'd1);
    check("fe_last",  32'(out_last),  32'd1);
    check("fe_data",  32'(out_data),  dv(0));
    tick();
    settle();
    check("fe_done_valid", 32'(out_valid), 32'd0);
    check("fe_done_count", 32'(count),     32'd0);
    tick();

    // Reset asserted on beat 2 of a burst.
    do_reset();
    req_valid = 4'hF;
    out_ready = 1'b1;
    repeat (7) tick();
    settle();
    check("mr_beat2", 32'(out_data), dv(2));
    rst_n = 1'b0;
    settle();
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_last",  32'(out_last),  32'd0);
    check("mr_busy",  32'(busy),      32'd0);
    check("mr_rd",    32'(buf_rd_en), 32'd0);
    check("mr_wr",    32'(buf_wr_en), 32'd0);
    check("mr_ready", 32'(req_ready), 32'd0);
    check("mr_count", 32'(count),     32'd0);
    req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    check("mr_post_busy",  32'(busy),  32'd0);
    check("mr_post_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/buffer_arbiter.md
# buffer_arbiter

Round-robin write arbiter and burst read sequencer for one shared `buffer` FIFO. Up to `NREQ` producers, typically the result drains of the systolic array, compete for the buffer's write port. The block then hands the stored words to a single consumer in fixed-length bursts, with a flush path for partial bursts. It sits beside the `buffer` instance in the parent, drives all of the buffer's control inputs, and tracks its own occupancy.

## Interface
Parameters:
- `NREQ`, 4: number of producers; must be at least 2.
- `DEPTH`, 8: depth of the attached `buffer`. Usable capacity is `DEPTH-1`.
- `DWIDTH`, 16: data word width.
- `BURST`, 4: words per normal burst; must satisfy 1 ≤ `BURST` ≤ `DEPTH-1`.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  `NREQ`: producer i has a word.
- `req_data`  in  `NREQ`×`DWIDTH`: producer words.
- `req_ready`  out  `NREQ`: one-hot grant; a word transfers when valid&ready.
- `buf_wr_en`, `buf_din`  out  1, `DWIDTH`: buffer write port.
- `buf_rd_en`  out  1: buffer read-pointer advance.
- `buf_dout`  in  `DWIDTH`: buffer head word (show-ahead).
- `buf_full`, `buf_empty`  in  1: buffer flags; used only by assertions.
- `flush`  in  1: pulse requesting drain of a partial burst.
- `out_valid`, `out_data`, `out_last`  out  1, `DWIDTH`, 1: consumer stream.
- `out_ready`  in  1: consumer accepts the word.
- `count`  out  `$clog2(DEPTH)+1`: current occupancy.
- `busy`  out  1: read FSM not in IDLE.

## Operation
- **Write arbitration**
  - Each cycle with `count < DEPTH-1`, grant the first valid requester at or after `rr_ptr`, searching cyclically.
  - `buf_wr_en` = any grant; `buf_din` = data of the granted requester.
  - On a grant, `rr_ptr` ← grant index + 1, wrapping at `NREQ`.
  - At full, all `req_ready` are 0 and `rr_ptr` holds.
  - Grants are combinational from `req_valid`, `rr_ptr` and `count`. A requester may hold valid without ready indefinitely.
- **Occupancy**
  - `count` +1 on write only, −1 on read only, unchanged on a simultaneous write and read.
  - `count` never exceeds `DEPTH-1` and never underflows.
- **Flush request**
  - A `flush` pulse sets `flush_pend`. It is cleared only at the end of a FLUSH burst.
  - `flush` arriving while `flush_pend` is already set is absorbed.
- **Read FSM states: IDLE, BURST, FLUSH**
  - IDLE → BURST when `count ≥ BURST`. `beat` ← 0 and `len` ← `BURST`.
  - Otherwise IDLE → FLUSH when `flush_pend` and `count > 0`. `len` ← `count` (snapshot) and `beat` ← 0.
  - BURST has priority over FLUSH.
  - `flush_pend` with `count == 0` stays pending until a word arrives.
  - In BURST and FLUSH:
    - `out_valid` = 1 and `out_data` = `buf_dout`.
    - `buf_rd_en` = `out_ready`; `beat` increments on each handshake.
    - `out_last` = (`beat == len-1`).
  - The handshake with `out_last` set returns the FSM to IDLE. A FLUSH exit also clears `flush_pend`.
  - Writes continue during bursts. Words written after the FLUSH snapshot are not part of that burst.
- Since `len ≤ count` at entry and only this block reads, the buffer is never empty during a burst. Assertion: `!(buf_rd_en && buf_empty)`.

## Timing
- `rst_n` low forces, asynchronously:
  - state IDLE; `count`, `beat`, `len`, `rr_ptr` and `flush_pend` all 0.
  - Consequently `out_valid`, `out_last`, `busy`, `buf_rd_en`, `buf_wr_en` and all `req_ready` are 0.
- The parent must hold the buffer in reset for at least one clock edge while `rst_n` is low. Reset mid-burst discards the burst with no `out_last`.
- Write latency:
  - A word granted in cycle t is counted from t+1.
  - The FSM can leave IDLE at the edge ending t+1, so `out_valid` rises no earlier than t+2.
- Bursts are back-to-back only through one IDLE cycle, giving a minimum of `BURST`+1 cycles per burst at full rate.
- `out_valid` must not drop and `out_data` must not change until the handshake completes. The consumer may stall arbitrarily.

## Structure
- Shared package `Config`: `NREQ`, `BURST` and `DWIDTH` defaults, plus typedef `arb_state_t` (IDLE, BURST, FLUSH).
- One natural sub-module: `rr_arbiter`.
  - Parameter `N`; inputs `req[N]`, `en`; outputs one-hot `gnt[N]`; owns `rr_ptr`.
  - Reused for bus arbitration elsewhere in the design.
- The FSM, occupancy counter and flush latch live in `buffer_arbiter`.

## Test plan
- **Round-robin fairness:** `NREQ`=4, all valid continuously, consumer ready → grants 0,1,2,3,0… and bursts of 4 with `out_last` on every 4th word, data in grant order.
- **Full back-pressure:** `out_ready`=0, 3 producers valid → 7 words accepted, then `req_ready`=0 and `count`=7 with no grant. Releasing `out_ready` → grants resume the cycle after the first read.
- **Flush:** 3 words written, `flush` pulsed → one FLUSH burst of 3, `out_last` on the 3rd, `flush_pend` cleared. A 4th word written mid-flush stays, with `count`=1.
- **Flush when empty:** `flush` with `count`=0, one word written 5 cycles later → a FLUSH burst of length 1.
- **Simultaneous write and read at full:** `count`=7 in BURST, `out_ready`=1 → at most one grant per cycle and `count` stays in the range 6..7, never 8.
- **Reset mid-burst:** `rst_n` low on beat 2 → all outputs 0 immediately. After release, state is IDLE and `count`=0.
